// File: rtl/connect_box_rv_pkg.sv
// Shared definitions for the ready-valid connection box: config field
// offsets, the config address and the config register layout.
package cb_rv_pkg;

  localparam int SEL_LSB   = 0;
  localparam int SEL_W     = 4;
  localparam int CONST_LSB = 4;
  localparam int CONST_W   = 16;
  localparam int COUNT_LSB = 24;
  localparam int COUNT_W   = 4;

  localparam logic [7:0] CFG_ADDR = 8'h00;

  typedef struct packed {
    logic [11:0] rsvd;
    logic [15:0] const_val;
    logic [3:0]  sel;
  } cfg_t;

endpackage

// File: rtl/connect_box_rv_if.sv
// Track-side and core-side handshake bundle of the connection box.
// The box itself is the slave: it consumes tracks and produces the core input.
interface connect_box_rv_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 8
) ();

  logic [NUM_TRACKS*WIDTH-1:0] in_data;
  logic [NUM_TRACKS-1:0]       in_valid;
  logic [NUM_TRACKS-1:0]       in_ready;
  logic [WIDTH-1:0]            out;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out, out_valid
  );

endinterface

// File: rtl/connect_box_rv_fifo.sv
// cb_rv_fifo: DEPTH-entry synchronous FIFO with flush. No empty bypass:
// a pushed word is visible on dout the cycle after the push edge. When
// empty, dout holds the last popped word (zero after reset).
module cb_rv_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = empty ? r_last : r_mem[r_rd];

  // Storage write; flushed or reset entries are simply abandoned.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !reset) begin
      r_mem[r_wr] <= din;
    end
  end

  // Pointers, occupancy and last-popped word; pointers wrap as DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= r_mem[r_rd];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/connect_box_rv.sv
// connect_box_rv: selects one of NUM_TRACKS ready-valid tracks (or, with
// CB_CONST_EN defined, a configured constant) into a DEPTH-entry FIFO that
// drives a tile input. Without CB_CONST_EN no constant register exists and
// sel==NUM_TRACKS behaves as "no source".
module connect_box_rv
  import cb_rv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 8,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_en,
  output logic [31:0]             read_data,
  connect_box_rv_if.slave         bus
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [3:0]  CONST_SEL = 4'(NUM_TRACKS);

  logic                  w_cfg_wr;
  logic [3:0]            r_sel;
  logic [WIDTH-1:0]      w_const;
  logic                  w_src_valid;
  logic [WIDTH-1:0]      w_src_data;
  logic [NUM_TRACKS-1:0] w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [WIDTH-1:0]      w_dout;
  cfg_t                  w_cfg;
  logic                  w_unused;

  assign w_cfg_wr = config_en && (config_addr[7:0] == CFG_ADDR);
  assign w_unused = ^{config_addr[31:8], config_data, w_cfg.rsvd};

  // Track select register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel <= '0;
    end else if (w_cfg_wr) begin
      r_sel <= config_data[SEL_LSB +: SEL_W];
    end
  end

`ifdef CB_CONST_EN
  logic [WIDTH-1:0] r_const;

  // Constant-source value register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_const <= '0;
    end else if (w_cfg_wr) begin
      r_const <= config_data[CONST_LSB +: WIDTH];
    end
  end

  assign w_const = r_const;
`else
  assign w_const = '0;
`endif

  // Source mux: track sel, the constant, or nothing.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = '0;
    for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
      if (r_sel == 4'(i)) begin
        w_src_valid = bus.in_valid[i];
        w_src_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
`ifdef CB_CONST_EN
    if (r_sel == CONST_SEL) begin
      w_src_valid = 1'b1;
      w_src_data  = w_const;
    end
`endif
  end

  // Ready fan-out: only the selected track, never from out_ready.
  always_comb begin
    w_ready = '0;
    for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
      w_ready[i] = (r_sel == 4'(i)) && !w_full && !w_cfg_wr && !reset;
    end
  end

  assign w_push = w_src_valid && !w_full && !w_cfg_wr && !reset;
  assign w_pop  = !w_empty && bus.out_ready && !w_cfg_wr;

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out       = w_dout;

  cb_rv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_cfg_wr),
    .din   (w_src_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Status readback: config fields plus FIFO occupancy.
  always_comb begin
    w_cfg           = '0;
    w_cfg.sel       = r_sel;
    w_cfg.const_val = 16'(w_const);
    read_data       = '0;
    read_data[CONST_LSB+CONST_W-1:0] = w_cfg[CONST_LSB+CONST_W-1:0];
    read_data[COUNT_LSB +: COUNT_W]  = 4'(w_count);
  end

endmodule

// File: tb/tb_connect_box_rv.sv
// Scoreboard bench for connect_box_rv (WIDTH=7, NUM_TRACKS=8, DEPTH=2).
// Accepted words are pushed to a reference queue and compared as they
// leave the DUT; ready, valid and readback are checked every cycle.
module tb_connect_box_rv;

  localparam int W = 7;
  localparam int N = 8;
  localparam int D = 2;

  logic        clk;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic [31:0] read_data;

  connect_box_rv_if #(.WIDTH(W), .NUM_TRACKS(N)) bus ();

  connect_box_rv #(.WIDTH(W), .NUM_TRACKS(N), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_en   (config_en),
    .read_data   (read_data),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [W-1:0] sb_q[$];
  logic [3:0]   m_sel;
  logic [W-1:0] m_const;
  logic [W-1:0] m_last;
  bit           m_known = 1'b0;
  bit           m_push;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic set_track(input int t, input logic [W-1:0] v);
    bus.in_data[t*W +: W] = v;
  endtask

  // One clock: check at mid-cycle, then advance the reference model at the edge.
  task automatic cycle();
    bit           cfg_wr;
    bit           full;
    bit           src_v;
    logic [W-1:0] src_d;
    logic [N-1:0] exp_rdy;
    logic [15:0]  c16;
    #1;
    cfg_wr  = config_en && (config_addr[7:0] == 8'h00);
    full    = (sb_q.size() == D);
    src_v   = 1'b0;
    src_d   = '0;
    if (m_sel < 4'(N)) begin
      src_v = bus.in_valid[m_sel[2:0]];
      src_d = bus.in_data[int'(m_sel)*W +: W];
    end
`ifdef CB_CONST_EN
    else if (m_sel == 4'(N)) begin
      src_v = 1'b1;
      src_d = m_const;
    end
`endif
    exp_rdy = '0;
    if (!reset && m_sel < 4'(N) && !full && !cfg_wr) exp_rdy[m_sel[2:0]] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (m_known) begin
      c16 = 16'(m_const);
      check("read_data", read_data, {4'b0, 4'(sb_q.size()), 4'b0, c16, m_sel});
      check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      check("out", 32'(bus.out), 32'(sb_q.size() != 0 ? sb_q[0] : m_last));
    end
    @(posedge clk);
    m_push = 1'b0;
    if (reset) begin
      sb_q.delete();
      m_sel   = '0;
      m_const = '0;
      m_last  = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (cfg_wr) begin
        sb_q.delete();
        m_sel = config_data[3:0];
`ifdef CB_CONST_EN
        m_const = config_data[4 +: W];
`else
        m_const = '0;
`endif
      end else begin
        if (sb_q.size() != 0 && bus.out_ready) m_last = sb_q.pop_front();
        if (src_v && !full) begin
          sb_q.push_back(src_d);
          m_push = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    config_addr = addr;
    config_data = data;
    config_en   = 1'b1;
    cycle();
    config_en   = 1'b0;
    config_data = 32'h0;
  endtask

  logic [W-1:0] stream [3];
  int           idx;

  initial begin
    reset         = 1'b1;
    config_addr   = 32'h0;
    config_data   = 32'h1F;
    config_en     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    config_data = 32'h0;
    repeat (2) cycle();

    // Track 1, continuous stream with consumer always ready.
    cfg_write(32'h0, 32'h1);
    set_track(1, 7'd4);
    bus.in_valid  = 8'b0000_0010;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    bus.in_valid = '0;
    repeat (2) cycle();

    // Write to a non-matching address is ignored.
    cfg_write(32'h1, 32'h5);
    cycle();

    // Track 6 backpressure: two accepted, then full, then drained in order.
    cfg_write(32'h0, 32'h6);
    bus.out_ready = 1'b0;
    stream[0] = 7'd34; stream[1] = 7'd35; stream[2] = 7'd36;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) bus.out_ready = 1'b1;
      bus.in_valid = (idx < 3) ? 8'b0100_0000 : 8'b0;
      set_track(6, (idx < 3) ? stream[idx] : 7'd0);
      cycle();
      if (m_push) idx++;
    end
    check("stream_done", 32'(idx), 32'd3);

    // Constant source (or no source when the feature is absent).
    cfg_write(32'h0, (32'd7 << 4) | 32'(N));
    repeat (4) cycle();

    // Fill FIFO from track 1, then a config write flushes it.
    bus.out_ready = 1'b0;
    cfg_write(32'h0, 32'h1);
    set_track(1, 7'd9);
    bus.in_valid = 8'b0000_0010;
    repeat (3) cycle();
    bus.in_valid = '0;
    cfg_write(32'h0, 32'h0);
    cycle();
    set_track(0, 7'd1);
    bus.in_valid  = 8'b0000_0001;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // sel beyond every source: nothing moves.
    bus.in_valid = 8'hFF;
    cfg_write(32'h0, 32'hF);
    repeat (4) cycle();

    // Reset in the middle of a stream.
    cfg_write(32'h0, 32'h2);
    set_track(2, 7'd77);
    bus.out_ready = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.in_valid = '0;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
